uart_fifo_port: RTL and testbench

- Buffered host-side adapter that drives the byte-level strobe interface of the j1a UART core (rd/valid, wr/busy) from the opposite end.
- Drains received bytes into an RX FIFO as soon as the core flags them, so the CPU can fall behind without stalling the core.
- Queues CPU writes in a TX FIFO and feeds them to the core whenever its transmitter is idle.
- Sits between the UART core and the j1a IO decode.

---
 rtl/uart_pkg.sv | 6 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_fifo_port.sv | 83 ++++++++
 tb/tb_uart_fifo_port.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared widths and default FIFO depths for the buffered UART host port.
package uart_pkg;
  localparam int BYTE_W    = 8;
  localparam int RX_AW_DEF = 4;
  localparam int TX_AW_DEF = 4;
endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with show-ahead head, 1-cycle push-to-head latency.
// Push-when-full and pop-when-empty are dropped; flags come from registered count.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [BYTE_W-1:0] mem [2**AW];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  // Count saturates exactly at 2^AW, so its MSB alone means full.
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_port.sv
// Host-side RX/TX buffering for the j1a UART strobe interface; cpu_wr to uart_wr is 1 cycle when idle.
// RX stalls the core (no uart_rd) when full; TX waits on uart_busy; overflow/underrun set sticky flags.
module uart_fifo_port
  import uart_pkg::*;
#(
  parameter int RX_AW = RX_AW_DEF,
  parameter int TX_AW = TX_AW_DEF
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              uart_valid,
  input  logic [BYTE_W-1:0] uart_rx_data,
  output logic              uart_rd,
  input  logic              uart_busy,
  output logic              uart_wr,
  output logic [BYTE_W-1:0] uart_tx_data,
  input  logic              cpu_rd,
  output logic [BYTE_W-1:0] cpu_rx_data,
  output logic              cpu_rx_valid,
  output logic [RX_AW:0]    cpu_rx_count,
  input  logic              cpu_wr,
  input  logic [BYTE_W-1:0] cpu_tx_data,
  output logic              cpu_tx_full,
  output logic              cpu_tx_empty,
  input  logic              cpu_clr,
  output logic              tx_drop,
  output logic              rx_underrun
);

  logic           rx_full;
  logic           rx_empty;
  logic           rx_hold;
  logic           tx_empty;
  logic           tx_hold;
  logic [TX_AW:0] tx_count;

  // The hold bits mask the cycle before the core reacts to a strobe,
  // so a byte is never read twice and a new byte never lands while busy is still low.
  assign uart_rd      = resetq & uart_valid & ~rx_full & ~rx_hold;
  assign uart_wr      = resetq & ~tx_empty & ~uart_busy & ~tx_hold;
  assign cpu_rx_valid = ~rx_empty;
  assign cpu_tx_empty = (tx_count == '0) & ~tx_hold & ~uart_busy;

  sync_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (uart_rd),
    .pop    (cpu_rd),
    .din    (uart_rx_data),
    .dout   (cpu_rx_data),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (cpu_rx_count)
  );

  sync_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk    (clk),
    .resetq (resetq),
    .push   (cpu_wr),
    .pop    (uart_wr),
    .din    (cpu_tx_data),
    .dout   (uart_tx_data),
    .full   (cpu_tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_hold     <= 1'b0;
      tx_hold     <= 1'b0;
      tx_drop     <= 1'b0;
      rx_underrun <= 1'b0;
    end else begin
      rx_hold     <= uart_rd;
      tx_hold     <= uart_wr;
      // A set event in the clearing cycle wins.
      tx_drop     <= (cpu_wr & cpu_tx_full) | (tx_drop & ~cpu_clr);
      rx_underrun <= (cpu_rd & rx_empty) | (rx_underrun & ~cpu_clr);
    end
  end

endmodule

// File: tb/tb_uart_fifo_port.sv
// Scoreboard bench: a UART core model and CPU stimulus queue expected bytes, a negedge monitor checks them.
module tb_uart_fifo_port;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       resetq;
  logic       uart_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rd;
  logic       uart_busy;
  logic       uart_wr;
  logic [7:0] uart_tx_data;
  logic       cpu_rd;
  logic [7:0] cpu_rx_data;
  logic       cpu_rx_valid;
  logic [4:0] cpu_rx_count;
  logic       cpu_wr;
  logic [7:0] cpu_tx_data;
  logic       cpu_tx_full;
  logic       cpu_tx_empty;
  logic       cpu_clr;
  logic       tx_drop;
  logic       rx_underrun;

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_src[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];

  logic core_busy    = 1'b0;
  logic force_busy   = 1'b0;
  logic busy_delay   = 1'b0;
  logic rx_drop_pend = 1'b0;
  int   busy_cnt     = 0;
  int   rd_pulses    = 0;
  logic prev_rd      = 1'b0;

  assign uart_busy = core_busy | force_busy;

  always #5 clk = ~clk;

  uart_fifo_port #(.RX_AW(4), .TX_AW(4)) dut (
    .clk          (clk),
    .resetq       (resetq),
    .uart_valid   (uart_valid),
    .uart_rx_data (uart_rx_data),
    .uart_rd      (uart_rd),
    .uart_busy    (uart_busy),
    .uart_wr      (uart_wr),
    .uart_tx_data (uart_tx_data),
    .cpu_rd       (cpu_rd),
    .cpu_rx_data  (cpu_rx_data),
    .cpu_rx_valid (cpu_rx_valid),
    .cpu_rx_count (cpu_rx_count),
    .cpu_wr       (cpu_wr),
    .cpu_tx_data  (cpu_tx_data),
    .cpu_tx_full  (cpu_tx_full),
    .cpu_tx_empty (cpu_tx_empty),
    .cpu_clr      (cpu_clr),
    .tx_drop      (tx_drop),
    .rx_underrun  (rx_underrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    logic got;
    resetq       = 1'b0;
    uart_valid   = 1'b1;
    uart_rx_data = 8'h41;
    cpu_rd       = 1'b0;
    cpu_wr       = 1'b0;
    cpu_tx_data  = 8'h00;
    cpu_clr      = 1'b0;
    rx_exp.push_back(8'h41);
    rx_src.push_back(8'h42);
    rx_src.push_back(8'h43);

    fork
      // UART core model: drops valid one cycle after an accepted rd, raises busy one cycle after wr.
      begin : core_model
        logic rd_s;
        logic wr_s;
        forever begin
          @(negedge clk);
          rd_s = uart_rd;
          wr_s = uart_wr;
          @(posedge clk);
          #1;
          if (resetq) begin
            if (rx_drop_pend) begin
              uart_valid   = 1'b0;
              rx_drop_pend = 1'b0;
            end else if (uart_valid && rd_s) begin
              rx_drop_pend = 1'b1;
            end else if (!uart_valid && rx_src.size() > 0) begin
              uart_rx_data = rx_src.pop_front();
              uart_valid   = 1'b1;
              rx_exp.push_back(uart_rx_data);
            end
            if (busy_delay) begin
              busy_delay = 1'b0;
              core_busy  = 1'b1;
              busy_cnt   = 40;
            end else if (busy_cnt > 0) begin
              busy_cnt--;
              if (busy_cnt == 0) core_busy = 1'b0;
            end
            if (wr_s) busy_delay = 1'b1;
          end
        end
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (uart_rd) begin
            check("rd_not_back_to_back", {31'd0, prev_rd}, 32'd0);
            rd_pulses++;
          end
          prev_rd = uart_rd;
          if (uart_wr) begin
            check("wr_outside_busy_lag", {31'd0, busy_delay}, 32'd0);
            if (tx_exp.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL tx_extra: got byte %02h, required none", uart_tx_data);
            end else begin
              check("tx_byte", {24'd0, uart_tx_data}, {24'd0, tx_exp.pop_front()});
            end
          end
          if (cpu_rd && cpu_rx_valid) begin
            if (rx_exp.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL rx_extra: got byte %02h, required none", cpu_rx_data);
            end else begin
              check("rx_byte", {24'd0, cpu_rx_data}, {24'd0, rx_exp.pop_front()});
            end
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "timeout");
      end
    join_none

    // Reset with a byte already waiting at the core
    repeat (2) @(negedge clk);
    check("reset_uart_rd", {31'd0, uart_rd}, 32'd0);
    check("reset_uart_wr", {31'd0, uart_wr}, 32'd0);
    check("reset_rx_valid", {31'd0, cpu_rx_valid}, 32'd0);
    check("reset_tx_empty", {31'd0, cpu_tx_empty}, 32'd1);
    check("reset_tx_full", {31'd0, cpu_tx_full}, 32'd0);
    check("reset_rx_count", {27'd0, cpu_rx_count}, 32'd0);
    @(posedge clk); #1;
    resetq = 1'b1;
    @(negedge clk);
    check("rd_first_cycle", {31'd0, uart_rd}, 32'd1);

    // RX burst 0x41..0x43
    n = 0;
    while ((rx_src.size() > 0 || uart_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rx_burst_finished", {31'd0, n < 100}, 32'd1);
    repeat (3) @(negedge clk);
    check("rx_burst_count", {27'd0, cpu_rx_count}, 32'd3);
    check("rx_burst_rd_pulses", rd_pulses, 32'd3);
    @(posedge clk); #1;
    cpu_rd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    @(negedge clk);
    check("rx_drained_valid", {31'd0, cpu_rx_valid}, 32'd0);
    check("rx_drained_count", {27'd0, cpu_rx_count}, 32'd0);

    // RX full: 16 bytes fill the FIFO, 0x99 must wait at the core
    for (int i = 0; i < 16; i++) rx_src.push_back(8'(8'h60 + i));
    rx_src.push_back(8'h99);
    n = 0;
    while (!(uart_valid && uart_rx_data == 8'h99) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rx_fill_reached_99", {31'd0, n < 300}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rx_full_no_rd", {31'd0, uart_rd}, 32'd0);
    end
    check("rx_full_count", {27'd0, cpu_rx_count}, 32'd16);
    @(posedge clk); #1;
    cpu_rd = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 2 && !got; k++) begin
      @(negedge clk);
      if (uart_rd) got = 1'b1;
    end
    check("rx_99_accepted", {31'd0, got}, 32'd1);
    @(negedge clk);
    check("rx_refill_count", {27'd0, cpu_rx_count}, 32'd16);
    @(posedge clk); #1;
    cpu_rd = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    @(negedge clk);
    check("rx_full_drained", {27'd0, cpu_rx_count}, 32'd0);
    check("rx_exp_consumed", rx_exp.size(), 32'd0);

    // TX feed: 0x55 then 0xAA against a core busy for 40 cycles per byte
    @(posedge clk); #1;
    cpu_wr      = 1'b1;
    cpu_tx_data = 8'h55;
    tx_exp.push_back(8'h55);
    @(posedge clk); #1;
    cpu_tx_data = 8'hAA;
    tx_exp.push_back(8'hAA);
    @(negedge clk);
    check("tx_one_cycle_latency", {31'd0, uart_wr}, 32'd1);
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    n = 0;
    @(negedge clk);
    while (!cpu_tx_empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_empty_after_two_busy", {31'd0, n >= 80 && n <= 86}, 32'd1);
    check("tx_feed_all_sent", tx_exp.size(), 32'd0);

    // TX overflow with the core held busy
    @(posedge clk); #1;
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cpu_wr      = 1'b1;
      cpu_tx_data = 8'(8'h10 + i);
      if (i < 16) tx_exp.push_back(cpu_tx_data);
      if (i == 16) begin
        @(negedge clk);
        check("tx_full_after_16", {31'd0, cpu_tx_full}, 32'd1);
        check("tx_drop_before_17th", {31'd0, tx_drop}, 32'd0);
      end
      @(posedge clk); #1;
    end
    cpu_wr = 1'b0;
    @(negedge clk);
    check("tx_drop_after_17th", {31'd0, tx_drop}, 32'd1);
    @(posedge clk); #1;
    force_busy = 1'b0;
    n = 0;
    @(negedge clk);
    while (!cpu_tx_empty && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("tx_overflow_drained", {31'd0, n < 1500}, 32'd1);
    check("tx_overflow_all_sent", tx_exp.size(), 32'd0);
    @(posedge clk); #1;
    cpu_clr = 1'b1;
    @(posedge clk); #1;
    cpu_clr = 1'b0;
    @(negedge clk);
    check("tx_drop_cleared", {31'd0, tx_drop}, 32'd0);

    // Underrun and clear race
    check("underrun_idle", {31'd0, rx_underrun}, 32'd0);
    @(posedge clk); #1;
    cpu_rd = 1'b1;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    @(negedge clk);
    check("underrun_set", {31'd0, rx_underrun}, 32'd1);
    @(posedge clk); #1;
    cpu_rd  = 1'b1;
    cpu_clr = 1'b1;
    @(posedge clk); #1;
    cpu_rd  = 1'b0;
    cpu_clr = 1'b0;
    @(negedge clk);
    check("underrun_set_beats_clr", {31'd0, rx_underrun}, 32'd1);
    @(posedge clk); #1;
    cpu_clr = 1'b1;
    @(posedge clk); #1;
    cpu_clr = 1'b0;
    @(negedge clk);
    check("underrun_cleared", {31'd0, rx_underrun}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
